// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART: register offsets,
// STATUS/CTRL bit positions, FSM state encodings and the divider floor helper.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_BUSY    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_FRAME_ERR  = 3;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] value,
                                            input logic [15:0] floor_value);
    return (value < floor_value) ? floor_value : value;
  endfunction

endpackage

// File: rtl/uart_periph_rx.sv
// Receive path: 2-flop synchronizer, start-bit qualification, mid-bit sampling
// of 8 data bits and the stop bit. Emits one-cycle delivery / frame-error strobes.
module uart_rx_core
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_i,
  input  logic [15:0] div_i,
  output logic        byte_strobe_o,
  output logic [7:0]  byte_o,
  output logic        frame_err_strobe_o
);

  logic        sync1_q;
  logic        sync2_q;
  logic        prev_q;
  rx_state_t   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;

  logic tick;
  logic fall;

  assign tick = (cnt_q == 16'd0);
  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (!tick) begin
        cnt_q <= cnt_q - 16'd1;
      end
      case (state_q)
        RX_IDLE: begin
          // Half a bit period puts every later sample near the bit centre.
          if (fall) begin
            state_q <= RX_START;
            cnt_q   <= (div_i >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (tick) begin
            if (sync2_q) begin
              state_q <= RX_IDLE;
            end else begin
              state_q   <= RX_DATA;
              cnt_q     <= div_i - 16'd1;
              bit_idx_q <= 3'd0;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            shift_q <= {sync2_q, shift_q[7:1]};
            cnt_q   <= div_i - 16'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            state_q <= sync2_q ? RX_IDLE : RX_WAIT;
          end
        end
        RX_WAIT: begin
          // A broken frame may leave the line low; re-arm only once it idles.
          if (sync2_q) begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_strobe_o      = (state_q == RX_STOP) & tick & sync2_q;
  assign frame_err_strobe_o = (state_q == RX_STOP) & tick & ~sync2_q;
  assign byte_o             = shift_q;

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: DATA/STATUS/BAUDDIV/CTRL registers, transmit FSM,
// registered read port and level interrupt; receive path lives in uart_rx_core.
module uart_periph
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter logic [15:0] MIN_DIV     = 16'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  logic [15:0] div_q, div_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        ferr_q, ferr_d;
  logic [31:0] rdata_q, rdata_d;

  tx_state_t   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_shift_q;
  logic        tx_q;

  logic        rx_strobe;
  logic [7:0]  rx_byte;
  logic        rx_ferr_strobe;

  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        rd_en;
  logic        data_rd;
  logic        tx_busy;
  logic        tx_start;
  logic        tx_tick;
  logic [31:0] status_word;
  logic        unused_bits;

  assign reg_sel     = addr[3:2];
  assign wr_en       = sel & we;
  assign rd_en       = sel & ~we;
  assign data_rd     = rd_en & (reg_sel == REG_DATA);
  assign tx_busy     = (tx_state_q != TX_IDLE);
  assign tx_start    = wr_en & (reg_sel == REG_DATA) & ~tx_busy;
  assign tx_tick     = (tx_cnt_q == 16'd0);
  assign status_word = {28'd0, ferr_q, overrun_q, rx_valid_q, tx_busy};
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  uart_rx_core u_rx (
    .clk                (clk),
    .rst_n              (rst_n),
    .uart_rx_i          (uart_rx),
    .div_i              (div_q),
    .byte_strobe_o      (rx_strobe),
    .byte_o             (rx_byte),
    .frame_err_strobe_o (rx_ferr_strobe)
  );

  always_comb begin
    div_d      = div_q;
    ctrl_d     = ctrl_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    ferr_d     = ferr_q;
    rdata_d    = rdata_q;

    if (wr_en) begin
      case (reg_sel)
        REG_BAUD: div_d  = clamp_div(wdata[15:0], MIN_DIV);
        REG_CTRL: ctrl_d = wdata[1:0];
        REG_STATUS: begin
          if (wdata[ST_RX_OVERRUN]) overrun_d = 1'b0;
          if (wdata[ST_FRAME_ERR])  ferr_d    = 1'b0;
        end
        default: ;
      endcase
    end

    if (data_rd) begin
      rx_valid_d = 1'b0;
    end
    // A read in the delivery cycle frees the holder, so the new byte is kept.
    if (rx_strobe) begin
      if (!rx_valid_q || data_rd) begin
        rx_byte_d  = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (rx_ferr_strobe) begin
      ferr_d = 1'b1;
    end

    if (rd_en) begin
      case (reg_sel)
        REG_DATA:   rdata_d = {24'd0, rx_byte_q};
        REG_STATUS: rdata_d = status_word;
        REG_BAUD:   rdata_d = {16'd0, div_q};
        REG_CTRL:   rdata_d = {30'd0, ctrl_q};
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DEFAULT_DIV;
      ctrl_q     <= 2'd0;
      rx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Every TX state lasts div_q clocks; the divider is re-read at each reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_start) begin
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
            tx_cnt_q   <= div_q - 16'd1;
            tx_shift_q <= wdata[7:0];
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_state_q <= TX_DATA;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_idx_q   <= 3'd0;
            tx_cnt_q   <= div_q - 16'd1;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt_q <= div_q - 16'd1;
            if (tx_idx_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_idx_q   <= tx_idx_q + 3'd1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  assign rdata   = rdata_q;
  assign uart_tx = tx_q;
  assign irq     = (rx_valid_q & ctrl_q[CTRL_RX_IE]) | (~tx_busy & ctrl_q[CTRL_TX_IE]);

endmodule
